// File: rtl/fc_ctrl_pkg.sv
// Shared types for the fc layer sequencer: FSM states, W/B/O beat phase, word width.
package fc_ctrl_pkg;

    localparam int FC_WORD_WIDTH = 32;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_STREAM,
        ST_WAIT_DONE,
        ST_WRITE
    } state_t;

    typedef enum logic [1:0] {
        PH_W,
        PH_B,
        PH_O
    } phase_t;

    function automatic phase_t next_phase(input phase_t ph);
        case (ph)
            PH_W:    return PH_B;
            PH_B:    return PH_O;
            default: return PH_W;
        endcase
    endfunction

    // Counters never collapse to zero width, even for a count of one.
    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/fc_ctrl_sel.sv
// Phase-driven 3:1 select of the W/B/O FIFO heads and one-hot pop/valid generation.
module fc_ctrl_sel
    import fc_ctrl_pkg::*;
(
    input  logic                     i_en,
    input  phase_t                   i_phase,
    input  logic                     i_w_empty,
    input  logic                     i_b_empty,
    input  logic                     i_o_empty,
    input  logic [FC_WORD_WIDTH-1:0] i_w_dout,
    input  logic [FC_WORD_WIDTH-1:0] i_b_dout,
    input  logic [FC_WORD_WIDTH-1:0] i_o_dout,
    output logic                     o_beat,
    output logic [2:0]               o_sel,
    output logic [FC_WORD_WIDTH-1:0] o_data
);

    logic                     w_empty_sel;
    logic [FC_WORD_WIDTH-1:0] w_dout_sel;
    logic [2:0]               w_onehot;

    always_comb begin
        w_empty_sel = 1'b1;
        w_dout_sel  = '0;
        w_onehot    = 3'b000;
        case (i_phase)
            PH_W: begin
                w_empty_sel = i_w_empty;
                w_dout_sel  = i_w_dout;
                w_onehot    = 3'b001;
            end
            PH_B: begin
                w_empty_sel = i_b_empty;
                w_dout_sel  = i_b_dout;
                w_onehot    = 3'b010;
            end
            PH_O: begin
                w_empty_sel = i_o_empty;
                w_dout_sel  = i_o_dout;
                w_onehot    = 3'b100;
            end
            default: begin
                w_empty_sel = 1'b1;
                w_dout_sel  = '0;
                w_onehot    = 3'b000;
            end
        endcase
    end

    // Only the selected FIFO's empty flag gates the beat; the others are never popped.
    assign o_beat = i_en && !w_empty_sel;
    assign o_sel  = o_beat ? w_onehot : 3'b000;
    assign o_data = o_beat ? w_dout_sel : '0;

endmodule

// File: rtl/fc_ctrl.sv
// Sequencer feeding W,B,O beats from three FWFT FIFOs into fc and writing one result per pass.
// Optional FC_CTRL_STALL_CNT_EN adds the stall_cycles counter and port.
module fc_ctrl
    import fc_ctrl_pkg::*;
#(
    parameter int DATA_WIDTH     = 8,
    parameter int FC_TOTAL_COUNT = 1024,
    parameter int NUM_OUTPUTS    = 1000
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     start,
    output logic                     busy,
    output logic                     done,
    input  logic                     w_empty,
    input  logic [FC_WORD_WIDTH-1:0] w_dout,
    output logic                     w_rd_en,
    input  logic                     b_empty,
    input  logic [FC_WORD_WIDTH-1:0] b_dout,
    output logic                     b_rd_en,
    input  logic                     o_empty,
    input  logic [FC_WORD_WIDTH-1:0] o_dout,
    output logic                     o_rd_en,
    output logic                     fc_start,
    output logic [FC_WORD_WIDTH-1:0] fc_data,
    output logic                     fc_weights_valid,
    output logic                     fc_biases_valid,
    output logic                     fc_ops_valid,
    input  logic                     fc_calculating,
    input  logic                     fc_done,
    input  logic [FC_WORD_WIDTH-1:0] fc_result,
    input  logic                     res_full,
    output logic                     res_wr_en,
    output logic [FC_WORD_WIDTH-1:0] res_din
`ifdef FC_CTRL_STALL_CNT_EN
    ,
    output logic [31:0]              stall_cycles
`endif
);

    localparam int BEATS = 3 * FC_TOTAL_COUNT;
    localparam int BCW   = cnt_width(BEATS);
    localparam int OCW   = cnt_width(NUM_OUTPUTS);
    localparam logic [BCW-1:0] BEAT_LAST = BCW'(BEATS - 1);
    localparam logic [OCW-1:0] OUT_LAST  = OCW'(NUM_OUTPUTS - 1);

    // fc packs four elements per data word.
    if (4 * DATA_WIDTH != FC_WORD_WIDTH) begin : g_width_chk
        $error("fc_ctrl: 4*DATA_WIDTH must equal FC_WORD_WIDTH");
    end

    state_t                   r_state;
    phase_t                   r_phase;
    logic [BCW-1:0]           r_beat_cnt;
    logic [OCW-1:0]           r_out_cnt;
    logic [FC_WORD_WIDTH-1:0] r_result;
    logic                     r_done;

    logic                     w_stream;
    logic                     w_beat;
    logic [2:0]               w_sel;
    logic [FC_WORD_WIDTH-1:0] w_data;

    assign w_stream = (r_state == ST_STREAM);

    fc_ctrl_sel u_sel (
        .i_en      (w_stream && !fc_calculating),
        .i_phase   (r_phase),
        .i_w_empty (w_empty),
        .i_b_empty (b_empty),
        .i_o_empty (o_empty),
        .i_w_dout  (w_dout),
        .i_b_dout  (b_dout),
        .i_o_dout  (o_dout),
        .o_beat    (w_beat),
        .o_sel     (w_sel),
        .o_data    (w_data)
    );

    // Pop and valid share the same cycle: the FIFO head goes straight to fc.
    assign w_rd_en          = w_sel[0];
    assign b_rd_en          = w_sel[1];
    assign o_rd_en          = w_sel[2];
    assign fc_weights_valid = w_sel[0];
    assign fc_biases_valid  = w_sel[1];
    assign fc_ops_valid     = w_sel[2];
    assign fc_data          = w_data;

    // fc_start drops in WRITE so fc sees a low cycle between passes.
    assign fc_start  = (r_state == ST_STREAM) || (r_state == ST_WAIT_DONE);
    assign busy      = (r_state != ST_IDLE);
    assign res_wr_en = (r_state == ST_WRITE) && !res_full;
    assign res_din   = r_result;
    assign done      = r_done;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state    <= ST_IDLE;
            r_phase    <= PH_W;
            r_beat_cnt <= '0;
            r_out_cnt  <= '0;
            r_result   <= '0;
            r_done     <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_state    <= ST_STREAM;
                        r_phase    <= PH_W;
                        r_beat_cnt <= '0;
                        r_out_cnt  <= '0;
                    end
                end
                ST_STREAM: begin
                    if (w_beat) begin
                        r_phase <= next_phase(r_phase);
                        if (r_beat_cnt == BEAT_LAST) begin
                            r_state <= ST_WAIT_DONE;
                        end else begin
                            r_beat_cnt <= r_beat_cnt + 1'b1;
                        end
                    end
                end
                ST_WAIT_DONE: begin
                    if (fc_done) begin
                        r_result <= fc_result;
                        r_state  <= ST_WRITE;
                    end
                end
                ST_WRITE: begin
                    if (!res_full) begin
                        if (r_out_cnt == OUT_LAST) begin
                            r_state <= ST_IDLE;
                            r_done  <= 1'b1;
                        end else begin
                            r_out_cnt  <= r_out_cnt + 1'b1;
                            r_beat_cnt <= '0;
                            r_phase    <= PH_W;
                            r_state    <= ST_STREAM;
                        end
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

`ifdef FC_CTRL_STALL_CNT_EN
    logic [31:0] r_stall_cnt;

    // Counts STREAM cycles that moved no data, whether from fc back-pressure or an empty FIFO.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_stall_cnt <= '0;
        end else if (r_state == ST_IDLE && start) begin
            r_stall_cnt <= '0;
        end else if (w_stream && !w_beat && r_stall_cnt != '1) begin
            r_stall_cnt <= r_stall_cnt + 1'b1;
        end
    end

    assign stall_cycles = r_stall_cnt;
`endif

endmodule

// File: tb/tb_fc_ctrl.sv
// Randomized bench for fc_ctrl against a beat/pass-level reference model.
module tb_fc_ctrl;

    localparam int FC    = 4;
    localparam int NO    = 2;
    localparam int BEATS = 3 * FC;

    logic        clock = 1'b0;
    logic        reset, start;
    logic        busy, done;
    logic        w_empty, b_empty, o_empty;
    logic [31:0] w_dout, b_dout, o_dout;
    logic        w_rd_en, b_rd_en, o_rd_en;
    logic        fc_start;
    logic [31:0] fc_data;
    logic        fc_weights_valid, fc_biases_valid, fc_ops_valid;
    logic        fc_calculating, fc_done;
    logic [31:0] fc_result;
    logic        res_full, res_wr_en;
    logic [31:0] res_din;
`ifdef FC_CTRL_STALL_CNT_EN
    logic [31:0] stall_cycles;
`endif

    always #5 clock = ~clock;

    fc_ctrl #(.DATA_WIDTH(8), .FC_TOTAL_COUNT(FC), .NUM_OUTPUTS(NO)) dut (
        .clock(clock), .reset(reset), .start(start), .busy(busy), .done(done),
        .w_empty(w_empty), .w_dout(w_dout), .w_rd_en(w_rd_en),
        .b_empty(b_empty), .b_dout(b_dout), .b_rd_en(b_rd_en),
        .o_empty(o_empty), .o_dout(o_dout), .o_rd_en(o_rd_en),
        .fc_start(fc_start), .fc_data(fc_data),
        .fc_weights_valid(fc_weights_valid), .fc_biases_valid(fc_biases_valid),
        .fc_ops_valid(fc_ops_valid), .fc_calculating(fc_calculating),
        .fc_done(fc_done), .fc_result(fc_result),
        .res_full(res_full), .res_wr_en(res_wr_en), .res_din(res_din)
`ifdef FC_CTRL_STALL_CNT_EN
        , .stall_cycles(stall_cycles)
`endif
    );

    int n_chk = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Source FIFO contents; kept topped up so emptiness is purely stimulus-controlled.
    logic [31:0] wq[$], bq[$], oq[$];
    bit nominal = 1'b1;

    // Reference model: where the current layer stands in terms of beats, results and writes.
    bit          m_active = 0;
    int          m_beats  = 0;
    bit          m_have   = 0;
    int          m_writes = 0;
    logic [31:0] m_res    = '0;
    bit          m_done   = 0;
    int          m_stall  = 0;

    int p_empty, p_calc, p_full, p_done, p_spur, p_start;
    int hold_b = 0, hold_calc = 0, hold_full = 0;
    bit arm_b = 0, arm_calc = 0, arm_full = 0, arm_rst = 0;

    task automatic refill();
        while (wq.size() < 3) wq.push_back(nominal ? 32'h0403_0201 : $urandom);
        while (bq.size() < 3) bq.push_back(nominal ? 32'h0000_0011 : $urandom);
        while (oq.size() < 3) oq.push_back(nominal ? 32'h0000_0022 : $urandom);
    endtask

    function automatic bit pct(input int p);
        return $urandom_range(99) < p;
    endfunction

    task automatic drive();
        bit waiting;
        waiting = m_active && m_beats == BEATS && !m_have;
        reset   = 1'b0;
        start   = m_active ? pct(p_start) : pct(40);
        fc_calculating = (hold_calc > 0) ? 1'b1 : pct(p_calc);
        if (hold_calc > 0) hold_calc--;
        w_empty = pct(p_empty);
        b_empty = (hold_b > 0) ? 1'b1 : pct(p_empty);
        if (hold_b > 0) hold_b--;
        o_empty = pct(p_empty);
        w_dout  = wq[0];
        b_dout  = bq[0];
        o_dout  = oq[0];
        fc_done   = waiting ? pct(p_done) : pct(p_spur);
        fc_result = nominal ? 32'h55 : $urandom;
        res_full  = (hold_full > 0) ? 1'b1 : pct(p_full);
        if (hold_full > 0) hold_full--;
    endtask

    task automatic chk_reset_outputs();
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_fc_start", fc_start, 0);
        chk("rst_rd_en", {o_rd_en, b_rd_en, w_rd_en}, 0);
        chk("rst_valid", {fc_ops_valid, fc_biases_valid, fc_weights_valid}, 0);
        chk("rst_fc_data", fc_data, 0);
        chk("rst_res_wr_en", res_wr_en, 0);
        chk("rst_res_din", res_din, 0);
`ifdef FC_CTRL_STALL_CNT_EN
        chk("rst_stall", stall_cycles, 0);
`endif
    endtask

    task automatic check_and_update();
        bit st, wt, wr, sel_empty, beat, next_done;
        int kind;
        logic [31:0] head;
        st   = m_active && m_beats < BEATS;
        wt   = m_active && m_beats == BEATS && !m_have;
        wr   = m_active && m_have;
        kind = m_beats % 3;
        sel_empty = (kind == 0) ? w_empty : (kind == 1) ? b_empty : o_empty;
        head      = (kind == 0) ? wq[0] : (kind == 1) ? bq[0] : oq[0];
        beat = st && !fc_calculating && !sel_empty;

        chk("rd_en", {o_rd_en, b_rd_en, w_rd_en}, beat ? (32'd1 << kind) : 32'd0);
        chk("valid", {fc_ops_valid, fc_biases_valid, fc_weights_valid}, beat ? (32'd1 << kind) : 32'd0);
        if (beat) chk("fc_data", fc_data, head);
        chk("fc_start", fc_start, st || wt);
        chk("busy", busy, m_active);
        chk("res_wr_en", res_wr_en, wr && !res_full);
        if (wr && !res_full) chk("res_din", res_din, m_res);
        chk("done", done, m_done);
`ifdef FC_CTRL_STALL_CNT_EN
        chk("stall", stall_cycles, m_stall);
`endif

        if (w_rd_en && wq.size() > 0) void'(wq.pop_front());
        if (b_rd_en && bq.size() > 0) void'(bq.pop_front());
        if (o_rd_en && oq.size() > 0) void'(oq.pop_front());
        refill();

        next_done = 0;
        if (!m_active) begin
            if (start) begin
                m_active = 1; m_beats = 0; m_have = 0; m_writes = 0; m_stall = 0;
            end
        end else if (st) begin
            if (beat) m_beats++;
            else m_stall++;
        end else if (wt) begin
            if (fc_done) begin
                m_res = fc_result;
                m_have = 1;
                if (arm_full) begin hold_full = 4; arm_full = 0; end
            end
        end else if (!res_full) begin
            m_writes++;
            m_have = 0;
            if (m_writes == NO) begin
                m_active = 0;
                next_done = 1;
            end else begin
                m_beats = 0;
            end
        end
        m_done = next_done;

        if (arm_b && m_active && m_beats == 1) begin hold_b = 5; arm_b = 0; end
        if (arm_calc && m_active && m_beats == 6) begin hold_calc = 3; arm_calc = 0; end
        if (arm_rst && m_active && m_beats == 7) begin
            arm_rst = 0;
            reset = 1'b1;
            #1;
            chk_reset_outputs();
            m_active = 0; m_done = 0; m_stall = 0; m_beats = 0; m_have = 0;
            hold_b = 0; hold_calc = 0; hold_full = 0;
        end
    endtask

    task automatic cycle();
        @(posedge clock);
        #1;
        drive();
        @(negedge clock);
        check_and_update();
    endtask

    task automatic run_layer(input string tag);
        bit seen = 0;
        for (int n = 0; n < 600; n++) begin
            cycle();
            if (m_active) seen = 1;
            if (seen && !m_active) return;
        end
        chk({tag, "_timeout"}, 1, 0);
    endtask

    task automatic set_clean();
        p_empty = 0; p_calc = 0; p_full = 0; p_done = 100; p_spur = 0; p_start = 0;
    endtask

    initial begin
        reset = 1'b1; start = 0;
        w_empty = 1; b_empty = 1; o_empty = 1;
        w_dout = 0; b_dout = 0; o_dout = 0;
        fc_calculating = 0; fc_done = 0; fc_result = 0; res_full = 0;
        refill();
        repeat (2) @(posedge clock);
        @(negedge clock);
        chk_reset_outputs();

        set_clean();
        run_layer("nominal");
        nominal = 1'b0;

        set_clean();
        arm_b = 1;
        run_layer("b_empty");
`ifdef FC_CTRL_STALL_CNT_EN
        chk("stall_b5", stall_cycles, 5);
`endif

        set_clean(); arm_calc = 1; run_layer("calc_hold");
        set_clean(); arm_full = 1; run_layer("res_full_hold");
        set_clean(); p_start = 100; run_layer("start_busy");
        set_clean(); arm_rst = 1; run_layer("reset_mid");
        set_clean(); run_layer("after_reset");

        p_empty = 25; p_calc = 20; p_full = 30; p_done = 30; p_spur = 10; p_start = 10;
        for (int l = 0; l < 25; l++) run_layer("random");

        repeat (3) cycle();
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

    initial begin
        #800000;
        $display("FAIL watchdog got=running exp=finished");
        $fatal(1, "watchdog");
    end

endmodule
